mac_inverse_div: RTL and testbench
==================================

// Module: mac_inverse_div
// PURPOSE
//  Inverse of the add/multiply/accumulate pipeline: given a result y and its
//  coefficient c, recovers s = (y - c) / c and remainder r.
//  Sits downstream of the MAC pipe for result checking and operand recovery.
//  Sequential restoring divider behind valid/ready handshakes on both sides.
// PARAMETERS
//  W  6  data width of y, c, q, r (unsigned)
// PORTS
//  clk        in   1  rising-edge clock, the only clock
//  rst        in   1  asynchronous reset, active-low (0 = reset)
//  in_valid   in   1  operand pair y/c valid
//  in_ready   out  1  block can accept operands (high only in IDLE)
//  y          in   W  MAC result, unsigned
//  c          in   W  coefficient, unsigned
//  out_valid  out  1  q/r/err valid, held until accepted
//  out_ready  in   1  downstream accepts result
//  q          out  W  quotient (y - c) / c
//  r          out  W  remainder (y - c) % c
//  err        out  1  1 = c == 0 or y < c; q/r forced
// BEHAVIOUR
//  - Reset (rst low, async): state IDLE, in_ready=1, out_valid=0, q=0, r=0, err=0.
//    Internal regs cleared. Applies mid-operation; the transaction in flight is dropped.
//  - FSM states: IDLE -> SUB -> DIV -> DONE -> IDLE.
//  - IDLE: in_ready=1. When in_valid&in_ready: latch y,c and go to SUB. Otherwise hold.
//  - SUB (1 cycle): d = y - c, computed W+1 wide.
//    If c==0 or y<c: err=1, q=all ones, r=0, go to DONE.
//    Otherwise: load dividend d and remainder 0, bit counter = W-1, go to DIV.
//  - DIV (exactly W cycles): restoring divide, MSB first.
//    Each cycle: rem = {rem, dividend MSB}. If rem >= c, subtract c and shift in 1, else shift in 0.
//    Counter decrements; when counter==0 at the edge, go to DONE.
//    Remainder reg is W+1 bits internally; no overflow possible.
//  - DONE: out_valid=1, q/r/err stable.
//    When out_valid&out_ready: out_valid=0 next cycle, go to IDLE.
//    in_ready is 0 throughout SUB/DIV/DONE; in_valid there is ignored and not queued.
//  - Latency, accept edge -> out_valid high:
//    W+2 cycles normal path, 2 cycles error path.
//    Minimum issue interval: W+3 cycles (out_ready tied high).
//  - out_ready high while not in DONE has no effect.
//    In DONE with out_ready low, outputs hold indefinitely.
//  - q, r, err change only on the SUB->DONE or DIV->DONE transition.
//    They keep their last values after the handshake until the next result.
// CONFIGURATION
//  INV_SELFCHECK_EN defined:
//    - Adds output chk_ok (1 bit, reset 0).
//    - In DONE with err=0: chk_ok = ((q*c + r + c) == y), width W*2+1 compare, registered on entry to DONE.
//    - chk_ok=0 whenever err=1.
//  INV_SELFCHECK_EN undefined:
//    - chk_ok port and its multiplier are absent.
//    - All other behaviour is identical.
// TESTING
//  1. y=33,c=3 -> out_valid 8 cycles after accept, q=10, r=0, err=0 (chk_ok=1).
//  2. y=36,c=5 -> q=6, r=1, err=0; y=63,c=1 -> q=62, r=0, err=0.
//  3. c=0, y=20 -> out_valid 2 cycles after accept, err=1, q=6'h3F, r=0.
//     y=2,c=3 -> same error result.
//  4. Backpressure: out_ready low 5 cycles in DONE -> q/r/out_valid held, in_ready=0.
//     Release -> IDLE; the next accept issues a new transaction.
//  5. Back-to-back, out_ready=1, in_valid=1: accepts every W+3=9 cycles.
//     in_valid pulses during busy are ignored.
//  6. rst low during DIV cycle 3 -> outputs zero immediately, in_ready=1.
//     After release, y=33,c=3 gives a clean q=10, r=0.

Source files
------------

// File: rtl/mac_inverse_div_if.sv
// mac_inverse_div_if: operand/result handshake bundle for mac_inverse_div.
// INV_SELFCHECK_EN adds the chk_ok result flag.
interface mac_inverse_div_if #(parameter int W = 6);
  logic in_valid, in_ready, out_valid, out_ready, err;
  logic [W-1:0] y, c, q, r;
`ifdef INV_SELFCHECK_EN
  logic chk_ok;
  modport slave (input in_valid, y, c, out_ready, output in_ready, out_valid, q, r, err, chk_ok);
  modport master (output in_valid, y, c, out_ready, input in_ready, out_valid, q, r, err, chk_ok);
`else
  modport slave (input in_valid, y, c, out_ready, output in_ready, out_valid, q, r, err);
  modport master (output in_valid, y, c, out_ready, input in_ready, out_valid, q, r, err);
`endif
endinterface

// File: rtl/mac_inverse_div.sv
// mac_inverse_div: recovers q=(y-c)/c, r=(y-c)%c with a sequential restoring divider.
// INV_SELFCHECK_EN adds chk_ok, a registered (q*c + r + c == y) check.
module mac_inverse_div #(parameter int W = 6) (
  input logic clk,
  input logic rst,
  mac_inverse_div_if.slave bus
);
  localparam int CW = W > 1 ? $clog2(W) : 1;
  localparam int PW = 2 * W + 1;
  typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] y_q, y_d, c_q, c_d, div_q, div_d, qo_q, qo_d, ro_q, ro_d;
  logic [W:0] rem_q, rem_d, diff;
  logic [W+1:0] trial;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, ge;
`ifdef INV_SELFCHECK_EN
  logic chk_q, chk_d;
`endif
  always_comb begin
    state_d = state_q;
    y_d = y_q;
    c_d = c_q;
    div_d = div_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    qo_d = qo_q;
    ro_d = ro_q;
    err_d = err_q;
`ifdef INV_SELFCHECK_EN
    chk_d = chk_q;
`endif
    diff = {1'b0, y_q} - {1'b0, c_q};
    trial = {rem_q, div_q[W-1]};
    ge = trial >= {2'b0, c_q};
    case (state_q)
      IDLE: if (bus.in_valid) begin
        y_d = bus.y;
        c_d = bus.c;
        state_d = SUB;
      end
      SUB: if (c_q == '0 || diff[W]) begin
        err_d = 1'b1;
        qo_d = '1;
        ro_d = '0;
`ifdef INV_SELFCHECK_EN
        chk_d = 1'b0;
`endif
        state_d = DONE;
      end else begin
        div_d = diff[W-1:0];
        rem_d = '0;
        cnt_d = CW'(W - 1);
        state_d = DIV;
      end
      DIV: begin
        rem_d = (W+1)'(ge ? trial - {2'b0, c_q} : trial);
        div_d = {div_q[W-2:0], ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          qo_d = div_d;
          ro_d = rem_d[W-1:0];
          err_d = 1'b0;
`ifdef INV_SELFCHECK_EN
          chk_d = (PW'(qo_d) * PW'(c_q) + PW'(ro_d) + PW'(c_q)) == PW'(y_q);
`endif
          state_d = DONE;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      y_q <= '0;
      c_q <= '0;
      div_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      qo_q <= '0;
      ro_q <= '0;
      err_q <= 1'b0;
`ifdef INV_SELFCHECK_EN
      chk_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q <= y_d;
      c_q <= c_d;
      div_q <= div_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      qo_q <= qo_d;
      ro_q <= ro_d;
      err_q <= err_d;
`ifdef INV_SELFCHECK_EN
      chk_q <= chk_d;
`endif
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.q = qo_q;
  assign bus.r = ro_q;
  assign bus.err = err_q;
`ifdef INV_SELFCHECK_EN
  assign bus.chk_ok = chk_q;
`endif
endmodule

// File: tb/tb_mac_inverse_div.sv
// tb_mac_inverse_div: scoreboard bench; driver pushes arithmetic expectations,
// monitor pops and compares on each new result.
module tb_mac_inverse_div;
  localparam int W = 6;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {int q; int r; int err; int lat; int acc;} exp_t;
  exp_t sb[$];
  bit ov_prev = 1'b0;
  int last_err = 0;

  mac_inverse_div_if #(.W(W)) bus();
  mac_inverse_div #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void expect_result(input int y, input int c, input int acc);
    exp_t e;
    if (c == 0 || y < c) e = '{(1 << W) - 1, 0, 1, 2, acc};
    else e = '{(y - c) / c, (y - c) % c, 0, W + 2, acc};
    last_err = e.err;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst && bus.out_valid && !ov_prev) begin
      if (sb.size() == 0) check("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("q", int'(bus.q), e.q);
        check("r", int'(bus.r), e.r);
        check("err", int'(bus.err), e.err);
        check("latency", cyc - e.acc + 1, e.lat);
        check("in_ready_in_done", int'(bus.in_ready), 0);
`ifdef INV_SELFCHECK_EN
        check("chk_ok", int'(bus.chk_ok), e.err ? 0 : 1);
`endif
      end
    end
    ov_prev = rst ? bus.out_valid : 1'b0;
  end

  task automatic send(input int y, input int c);
    int n = 0;
    bus.y = W'(y);
    bus.c = W'(c);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", 0, 1);
    else expect_result(y, c, cyc + 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.in_ready && sb.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("out_valid_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_q", int'(bus.q), 0);
    check("rst_r", int'(bus.r), 0);
    check("rst_err", int'(bus.err), 0);
`ifdef INV_SELFCHECK_EN
    check("rst_chk_ok", int'(bus.chk_ok), 0);
`endif
  endtask

  initial begin
    int last_acc;
    int prev_err;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.y = '0;
    bus.c = '0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    send(33, 3); wait_idle();
    send(36, 5); wait_idle();
    send(63, 1); wait_idle();
    send(20, 0); wait_idle();
    send(2, 3);  wait_idle();
    send(0, 0);  wait_idle();
    send(5, 5);  wait_idle();

    bus.out_ready = 1'b0;
    send(36, 5);
    wait_ov();
    bus.in_valid = 1'b1;
    bus.y = 6'd50;
    bus.c = 6'd2;
    repeat (5) begin
      @(negedge clk);
      check("hold_out_valid", int'(bus.out_valid), 1);
      check("hold_q", int'(bus.q), 6);
      check("hold_r", int'(bus.r), 1);
      check("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", int'(bus.out_valid), 0);
    check("release_in_ready", int'(bus.in_ready), 1);
    send(50, 2); wait_idle();

    last_acc = -1;
    prev_err = 0;
    bus.in_valid = 1'b1;
    repeat (80) begin
      bus.c = W'($urandom_range(1, 9));
      bus.y = W'($urandom_range(0, 63));
      if (bus.in_ready) begin
        if (last_acc >= 0) check("issue_interval", cyc + 1 - last_acc, prev_err ? 3 : W + 3);
        expect_result(int'(bus.y), int'(bus.c), cyc + 1);
        prev_err = last_err;
        last_acc = cyc + 1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_idle();

    send(33, 3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(33, 3); wait_idle();

    repeat (40) begin
      int c;
      c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(1, 9);
      send($urandom_range(0, 63), c);
      wait_idle();
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
